// File: rtl/noise_poly_streamer.sv
// rtl/noise_poly_streamer.sv - noise polynomial bank reader and coefficient streamer
//
// Purpose: walks the seven stored noise polynomials (r[0..2], e1[0..2], e2)
// through a synchronous read port and serialises the coefficients as a
// valid/ready stream. A 2-entry output FIFO decouples the stream from the bank.
// Reads are issued only when the FIFO is guaranteed to have room for the data.
//
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   start                 begin a run (sampled only when idle)
//   noise_ready           bank contents valid level
//   busy, done, err       status: not idle / one-cycle completion pulse /
//                         sticky coefficient range error
//   rd_en, rd_poly,       bank read strobe and address
//   rd_idx
//   rd_data               bank data, one cycle after rd_en
//   out_valid, out_ready  stream handshake
//   out_coef, out_poly,   stream beat: coefficient with its polynomial and
//   out_idx               coefficient index
//   out_last, out_end     last coefficient of a polynomial / of the run
//
// Optional build macro: NOISE_MOD_Q_EN maps negative coefficients into [0, Q)
// as they are written into the FIFO.

module noise_poly_streamer #(
    parameter int COEF_W   = 16,
    parameter int N        = 256,
    parameter int NUM_POLY = 7
`ifdef NOISE_MOD_Q_EN
    ,
    parameter int Q        = 3329
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              noise_ready,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              rd_en,
    output logic [2:0]        rd_poly,
    output logic [7:0]        rd_idx,
    input  logic [COEF_W-1:0] rd_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [COEF_W-1:0] out_coef,
    output logic [2:0]        out_poly,
    output logic [7:0]        out_idx,
    output logic              out_last,
    output logic              out_end
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_SRC,
        S_STREAM,
        S_DRAIN,
        S_DONE
    } state_t;

    localparam logic [7:0]               LAST_IDX  = 8'(N - 1);
    localparam logic [2:0]               LAST_POLY = 3'(NUM_POLY - 1);
    localparam logic signed [COEF_W-1:0] RANGE_HI  = COEF_W'(2);
    localparam logic signed [COEF_W-1:0] RANGE_LO  = COEF_W'(-2);

    state_t            state_q;
    logic              busy_q;
    logic              done_q;
    logic              err_q;
    logic              end_acc_q;
    logic [2:0]        poly_q;
    logic [7:0]        idx_q;

    logic              inflight_q;
    logic [2:0]        tag_poly_q;
    logic [7:0]        tag_idx_q;

    logic [COEF_W-1:0] fifo_coef_q [2];
    logic [2:0]        fifo_poly_q [2];
    logic [7:0]        fifo_idx_q  [2];
    logic              wr_ptr_q;
    logic              rd_ptr_q;
    logic [1:0]        count_q;

    logic              pop;
    logic              push;
    logic              credit_ok;
    logic              last_read;
    logic              drain_done;
    logic              raw_bad;
    logic [COEF_W-1:0] cap_coef;

    assign out_valid = (count_q != 2'd0);
    assign pop       = out_valid & out_ready;
    // rd_data always arrives the cycle after rd_en, so every in-flight read
    // becomes a push.
    assign push      = inflight_q;

    // Entries held plus the read in flight must stay below 2 after this
    // cycle's pop; otherwise the returning data could find the FIFO full.
    assign credit_ok = ({1'b0, count_q} + {2'b00, inflight_q}) < (3'd2 + {2'b00, pop});
    assign rd_en     = (state_q == S_STREAM) & credit_ok;
    assign rd_poly   = poly_q;
    assign rd_idx    = idx_q;
    assign last_read = rd_en & (poly_q == LAST_POLY) & (idx_q == LAST_IDX);

    assign out_coef  = out_valid ? fifo_coef_q[rd_ptr_q] : '0;
    assign out_poly  = out_valid ? fifo_poly_q[rd_ptr_q] : '0;
    assign out_idx   = out_valid ? fifo_idx_q[rd_ptr_q]  : '0;
    assign out_last  = out_valid & (out_idx == LAST_IDX);
    assign out_end   = out_last & (out_poly == LAST_POLY);

    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;

    // The range check always looks at the raw bank value.
    assign raw_bad   = ($signed(rd_data) > RANGE_HI) || ($signed(rd_data) < RANGE_LO);

`ifdef NOISE_MOD_Q_EN
    assign cap_coef  = rd_data[COEF_W-1] ? (rd_data + COEF_W'(Q)) : rd_data;
`else
    assign cap_coef  = rd_data;
`endif

    // The run is complete once the FIFO empties this cycle with nothing in
    // flight and the end beat has been (or is now being) accepted; done then
    // lands the cycle right after the final transfer.
    assign drain_done = (state_q == S_DRAIN) & ~inflight_q
                      & ((count_q == 2'd0) | ((count_q == 2'd1) & pop))
                      & (end_acc_q | (pop & out_end));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            end_acc_q <= 1'b0;
            poly_q    <= '0;
            idx_q     <= '0;
        end else begin
            done_q <= 1'b0;
            if (pop && out_end) begin
                end_acc_q <= 1'b1;
            end
            if (push && raw_bad) begin
                err_q <= 1'b1;
            end
            if (rd_en) begin
                if (idx_q == LAST_IDX) begin
                    idx_q  <= '0;
                    poly_q <= poly_q + 3'd1;
                end else begin
                    idx_q  <= idx_q + 8'd1;
                end
            end
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q   <= S_WAIT_SRC;
                        busy_q    <= 1'b1;
                        err_q     <= 1'b0;
                        end_acc_q <= 1'b0;
                        poly_q    <= '0;
                        idx_q     <= '0;
                    end
                end
                S_WAIT_SRC: begin
                    if (noise_ready) begin
                        state_q <= S_STREAM;
                    end
                end
                S_STREAM: begin
                    if (last_read) begin
                        state_q <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (drain_done) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inflight_q <= 1'b0;
            tag_poly_q <= '0;
            tag_idx_q  <= '0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            count_q    <= '0;
            for (int k = 0; k < 2; k++) begin
                fifo_coef_q[k] <= '0;
                fifo_poly_q[k] <= '0;
                fifo_idx_q[k]  <= '0;
            end
        end else begin
            inflight_q <= rd_en;
            if (rd_en) begin
                tag_poly_q <= poly_q;
                tag_idx_q  <= idx_q;
            end
            if (push) begin
                fifo_coef_q[wr_ptr_q] <= cap_coef;
                fifo_poly_q[wr_ptr_q] <= tag_poly_q;
                fifo_idx_q[wr_ptr_q]  <= tag_idx_q;
                wr_ptr_q              <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_q + {1'b0, push} - {1'b0, pop};
        end
    end

endmodule

// File: tb/tb_noise_poly_streamer.sv
// tb/tb_noise_poly_streamer.sv - self-checking bench for noise_poly_streamer

module tb_noise_poly_streamer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        noise_ready = 1'b1;
    logic        out_ready = 1'b0;
    logic [15:0] rd_data = 16'd0;
    logic        busy, done, err, rd_en, out_valid, out_last, out_end;
    logic [2:0]  rd_poly, out_poly;
    logic [7:0]  rd_idx, out_idx;
    logic [15:0] out_coef;

    noise_poly_streamer dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .noise_ready (noise_ready),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .rd_en       (rd_en),
        .rd_poly     (rd_poly),
        .rd_idx      (rd_idx),
        .rd_data     (rd_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_coef    (out_coef),
        .out_poly    (out_poly),
        .out_idx     (out_idx),
        .out_last    (out_last),
        .out_end     (out_end)
    );

    always #5 clk = ~clk;

    int bankv [7][256];

    always @(posedge clk) begin
        if (rd_en) rd_data <= 16'(bankv[rd_poly][rd_idx]);
    end

    int checks = 0;
    int errors = 0;
    int cyc_n = 0;
    logic [28:0] exp_q [$];
    int issued, accepted, done_cnt, done_cyc, last_acc_cyc;
    int first_rd, first_valid, start_cyc;
    bit prev_stall;
    logic [28:0] prev_beat;
    logic err_first_valid, err_at_317, err_at_done;
    logic [15:0] coef_317;
    logic [15:0] first_coef [5];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [28:0] beat_of(int p, int i);
        int v;
        v = bankv[p][i];
`ifdef NOISE_MOD_Q_EN
        if (v < 0) v = v + 3329;
`endif
        return {16'(v), 3'(p), 8'(i), (i == 255), (p == 6 && i == 255)};
    endfunction

    task automatic fill_nominal();
        for (int p = 0; p < 7; p++)
            for (int i = 0; i < 256; i++)
                bankv[p][i] = ((p * 7 + i) % 5) - 2;
    endtask

    task automatic fill_random();
        for (int p = 0; p < 7; p++)
            for (int i = 0; i < 256; i++)
                bankv[p][i] = int'($urandom_range(0, 4)) - 2;
    endtask

    // One clock cycle: inputs are already applied; observe at the falling edge.
    task automatic cyc();
        logic        pop;
        logic [28:0] beat;
        @(negedge clk);
        beat = {out_coef, out_poly, out_idx, out_last, out_end};
        pop  = out_valid && out_ready;
        if (prev_stall) chk("hold", 32'({out_valid, beat}), 32'({1'b1, prev_beat}));
        if (rd_en) begin
            chk("credit", 32'((issued - accepted - (pop ? 1 : 0)) < 2), 32'd1);
            if (first_rd < 0) first_rd = cyc_n;
            issued++;
        end
        if (out_valid && first_valid < 0) begin
            first_valid     = cyc_n;
            err_first_valid = err;
        end
        if (out_valid && out_poly == 3'd3 && out_idx == 8'd17) err_at_317 = err;
        if (pop) begin
            if (exp_q.size() == 0) chk("extra_beat", 32'(beat), 32'h1fffffff);
            else chk("beat", 32'(beat), 32'(exp_q.pop_front()));
            if (accepted < 5) first_coef[accepted] = out_coef;
            if (out_poly == 3'd3 && out_idx == 8'd17) coef_317 = out_coef;
            accepted++;
            last_acc_cyc = cyc_n;
        end
        if (done) begin
            done_cnt++;
            done_cyc    = cyc_n;
            err_at_done = err;
        end
        prev_stall = out_valid && !out_ready;
        prev_beat  = beat;
        @(posedge clk);
        #1;
        cyc_n++;
    endtask

    task automatic begin_run();
        exp_q.delete();
        for (int p = 0; p < 7; p++)
            for (int i = 0; i < 256; i++)
                exp_q.push_back(beat_of(p, i));
        issued = 0; accepted = 0; done_cnt = 0; done_cyc = -1; last_acc_cyc = -1;
        first_rd = -1; first_valid = -1; prev_stall = 0;
        err_first_valid = 1'bx; err_at_317 = 1'bx; err_at_done = 1'bx; coef_317 = 'x;
        start = 1'b1;
        start_cyc = cyc_n;
        cyc();
        start = 1'b0;
    endtask

    task automatic run_to_done(input int budget, input int pct, input bit chaos);
        int n;
        n = 0;
        while (done_cnt == 0 && n < budget) begin
            out_ready = ($urandom_range(0, 99) < pct);
            if (chaos) begin
                noise_ready = 1'($urandom_range(0, 1));
                start       = (accepted < 1000) && ($urandom_range(0, 1) == 1);
            end
            cyc();
            n++;
        end
        start = 1'b0; noise_ready = 1'b1; out_ready = 1'b1;
        chk("done_seen", 32'(done_cnt), 32'd1);
        repeat (3) cyc();
        chk("beats", 32'(accepted), 32'd1792);
        chk("exp_left", 32'(exp_q.size()), 32'd0);
        chk("done_after_last", 32'(done_cyc), 32'(last_acc_cyc + 1));
        chk("done_pulses", 32'(done_cnt), 32'd1);
        chk("idle_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        int n;
        int exp5 [5];
`ifdef NOISE_MOD_Q_EN
        exp5 = '{3327, 3328, 0, 1, 2};
`else
        exp5 = '{32'hfffe, 32'hffff, 0, 1, 2};
`endif
        // reset state
        rst = 1'b1;
        cyc(); cyc();
        chk("rst_ctrl", 32'({busy, done, err, rd_en, out_valid}), 32'd0);
        chk("rst_out", 32'({out_coef, out_poly, out_idx, out_last, out_end}), 32'd0);
        chk("rst_rd", 32'({rd_poly, rd_idx}), 32'd0);
        rst = 1'b0;
        cyc(); cyc();

        // nominal run
        fill_nominal();
        noise_ready = 1'b1; out_ready = 1'b1;
        begin_run();
        chk("nom_busy_c1", 32'(busy), 32'd1);
        run_to_done(3000, 100, 1'b0);
        chk("nom_first_rd", 32'(first_rd - start_cyc), 32'd2);
        chk("nom_first_valid", 32'(first_valid - start_cyc), 32'd4);
        chk("nom_err", 32'(err), 32'd0);
        for (int k = 0; k < 5; k++) chk("nom_coef_k", 32'(first_coef[k]), 32'(exp5[k]));

        // backpressure, noise_ready wobble, starts while busy
        fill_random();
        begin_run();
        run_to_done(12000, 40, 1'b1);

        // late source
        fill_nominal();
        noise_ready = 1'b0; out_ready = 1'b1;
        begin_run();
        chk("late_busy_c1", 32'(busy), 32'd1);
        repeat (19) cyc();
        noise_ready = 1'b1;
        run_to_done(3000, 100, 1'b0);
        chk("late_first_rd", 32'(first_rd - start_cyc), 32'd21);

        // range error
        bankv[3][17] = 5;
        begin_run();
        run_to_done(6000, 70, 1'b0);
        chk("err_before", 32'(err_first_valid), 32'd0);
        chk("err_at_beat", 32'(err_at_317), 32'd1);
        chk("err_at_done", 32'(err_at_done), 32'd1);
        chk("err_sticky", 32'(err), 32'd1);
        chk("coef_5", 32'(coef_317), 32'd5);

        // next start clears err; reset mid-run
        bankv[3][17] = 1;
        begin_run();
        chk("err_clear", 32'(err), 32'd0);
        n = 0;
        while (accepted < 300 && n < 5000) begin
            out_ready = ($urandom_range(0, 99) < 60);
            cyc();
            n++;
        end
        chk("pre_rst_beats", 32'(accepted), 32'd300);
        rst = 1'b1;
        #1;
        chk("mid_rst_ctrl", 32'({busy, done, err, rd_en, out_valid}), 32'd0);
        chk("mid_rst_out", 32'({out_coef, out_poly, out_idx, out_last, out_end}), 32'd0);
        prev_stall = 0;
        cyc(); cyc();
        chk("rst_no_done", 32'(done_cnt), 32'd0);
        rst = 1'b0;
        cyc();
        out_ready = 1'b1;
        begin_run();
        run_to_done(3000, 100, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
